// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants and helpers for the parity frame transmitter
// Contents: FSM state encoding (3-bit), serial line idle level, 4-input parity cell.
package parity_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  // The generator's basic building block: parity of a 4-bit group.
  function automatic logic parity4(input logic [3:0] v);
    return v[0] ^ v[1] ^ v[2] ^ v[3];
  endfunction

endpackage

// File: rtl/parity_tree.sv
// rtl/parity_tree.sv - combinational XOR-reduction parity of a DATA_W-bit word
// Ports:
//   data    in  DATA_W  word to reduce
//   odd_sel in  1       0: even parity (XOR of bits), 1: odd parity (inverted)
//   parity  out 1       resulting parity bit
module parity_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              parity
);

  localparam int NCELL = (DATA_W + 3) / 4;

  logic [NCELL*4-1:0] padded;
  logic [NCELL-1:0]   cell_par;

  // Zero-pad up to a whole number of 4-bit cells; zeros do not affect parity.
  always_comb begin
    padded               = '0;
    padded[DATA_W-1:0]   = data;
  end

  for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
    assign cell_par[gi] = parity4(padded[gi*4 +: 4]);
  end

  assign parity = (^cell_par) ^ odd_sel;

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - serial frame transmitter: start, data LSB-first, parity, stop
// Optional build macro: PARITY_ODD_EN (odd parity instead of even).
// Ports:
//   clk       in  1       system clock, rising edge
//   rst_n     in  1       asynchronous active-low reset
//   in_data   in  DATA_W  word to transmit
//   in_valid  in  1       producer has a word on in_data
//   in_ready  out 1       block can accept a word (IDLE only)
//   tx_out    out 1       serial line, idles high
//   busy      out 1       frame in progress
//   done      out 1       one-cycle pulse on the first IDLE cycle after STOP
//   par_bit   out 1       parity of the most recently accepted word
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done,
  output logic              par_bit
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

`ifdef PARITY_ODD_EN
  localparam logic ODD_SEL = 1'b1;
`else
  localparam logic ODD_SEL = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_d;
  logic              tx_d;
  logic              done_d;
  logic              tree_par;
  logic              accept;
  logic              bit_end;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data    (in_data),
    .odd_sel (ODD_SEL),
    .parity  (tree_par)
  );

  assign accept  = in_valid & in_ready;
  assign bit_end = (clk_cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_bit;

    // Every non-IDLE state holds its bit for CLKS_PER_BIT cycles.
    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (accept) begin
          shift_d = in_data;
          par_d   = tree_par;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_MAX) begin
            bit_cnt_d = '0;
            state_d   = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so the line level
  // changes on the same edge the FSM enters a state.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = LINE_IDLE;
    endcase
  end

  assign done_d = (state_q == S_STOP) && (state_d == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit   <= 1'b0;
      tx_out    <= LINE_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bit   <= par_d;
      tx_out    <= tx_d;
      in_ready  <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - self-checking bench for parity_frame_tx (CLKS_PER_BIT 4 and 1)
module tb_parity_frame_tx;

  logic clk    = 1'b0;
  bit   clk_en = 1'b0;
  logic rst_n  = 1'b1;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy, a_done, a_par;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done, b_par;

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .tx_out(a_tx), .busy(a_busy), .done(a_done), .par_bit(a_par)
  );

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .tx_out(b_tx), .busy(b_busy), .done(b_done), .par_bit(b_par)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;
  bit sel   = 1'b0;
  int cpb   = 4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic o_tx();    return sel ? b_tx    : a_tx;    endfunction
  function automatic logic o_ready(); return sel ? b_ready : a_ready; endfunction
  function automatic logic o_busy();  return sel ? b_busy  : a_busy;  endfunction
  function automatic logic o_done();  return sel ? b_done  : a_done;  endfunction
  function automatic logic o_par();   return sel ? b_par   : a_par;   endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else     begin a_valid = v; a_data = d; end
  endtask

  // Reference frame: bit slot idx of the 11-slot frame for word w.
  function automatic logic exp_parity(input logic [7:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  function automatic logic exp_bit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (idx == 9) return exp_parity(w);
    return 1'b1;
  endfunction

  // Called at a negedge. Returns at the negedge inside the done cycle.
  task automatic do_frame(input logic [7:0] w, input bit hold);
    int  n;
    logic ep;
    ep = exp_parity(w);
    n  = 0;
    while (o_ready() !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    drive(1'b1, w);
    @(posedge clk);
    for (int k = 1; k <= 11 * cpb; k++) begin
      @(negedge clk);
      if (hold) drive(1'b1, 8'($urandom));
      else      drive(1'b0, w);
      check($sformatf("tx w=%02h k=%0d", w, k), o_tx(), exp_bit(w, (k - 1) / cpb));
      check("busy_in_frame", o_busy(), 1'b1);
      check("ready_in_frame", o_ready(), 1'b0);
      check("done_in_frame", o_done(), 1'b0);
      if (k == 1) check("par_after_accept", o_par(), ep);
    end
    @(negedge clk);
    check("done_pulse", o_done(), 1'b1);
    check("ready_at_done", o_ready(), 1'b1);
    check("busy_at_done", o_busy(), 1'b0);
    check("tx_idle_at_done", o_tx(), 1'b1);
    check($sformatf("par w=%02h", w), o_par(), ep);
  endtask

  task automatic idle_after();
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("done_single", o_done(), 1'b0);
    check("tx_idle", o_tx(), 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx"}, o_tx(), 1'b1);
    check({tag, "_ready"}, o_ready(), 1'b1);
    check({tag, "_busy"}, o_busy(), 1'b0);
    check({tag, "_done"}, o_done(), 1'b0);
    check({tag, "_par"}, o_par(), 1'b0);
  endtask

  initial begin
    // Reset with the clock stopped: outputs must settle without any edge.
    #2 rst_n = 1'b0;
    #1;
    sel = 1'b0; check_reset_vals("rst_noclk_a");
    sel = 1'b1; check_reset_vals("rst_noclk_b");
    sel = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 1'b0; cpb = 4;
    do_frame(8'hA5, 1'b0); idle_after();
    do_frame(8'h07, 1'b0); idle_after();
    do_frame(8'h00, 1'b0); idle_after();
    do_frame(8'hFF, 1'b0); idle_after();
    for (int i = 0; i < 6; i++) begin
      do_frame(8'($urandom), 1'b0);
      idle_after();
    end

    // Back-to-back with in_valid held and in_data churning mid-frame.
    do_frame(8'($urandom), 1'b1);
    do_frame(8'($urandom), 1'b1);
    do_frame(8'($urandom), 1'b0);
    idle_after();

    // Reset asserted in cycle 20 of a frame (inside DATA).
    drive(1'b1, 8'h5A);
    @(posedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    drive(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_residual_tx", o_tx(), 1'b1);
      check("no_residual_busy", o_busy(), 1'b0);
    end
    do_frame(8'($urandom), 1'b0); idle_after();

    // One clock per bit.
    sel = 1'b1; cpb = 1;
    do_frame(8'h3C, 1'b0); idle_after();
    for (int i = 0; i < 4; i++) begin
      do_frame(8'($urandom), 1'b0);
      idle_after();
    end
    do_frame(8'($urandom), 1'b1);
    do_frame(8'($urandom), 1'b0);
    idle_after();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Serial frame transmitter that sequences the team's parity-generator datapath.
- Accepts one data word per valid/ready handshake and computes its parity with an XOR-reduction tree.
- Shifts out start bit, data LSB-first, parity bit and stop bit on a single line, each bit held for a fixed number of clocks.
- Sits between a word producer and an off-chip or board-level serial link.

Parameters:
- DATA_W, 8, data word width in bits; must be >= 2.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word; high only in IDLE.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress; high in any state other than IDLE.
- done  output  1  single-cycle pulse when a frame completes.
- par_bit  output  1  parity bit of the most recently accepted word.

Behaviour:
- Reset, async on rst_n=0: state=IDLE, tx_out=1, in_ready=1, busy=0, done=0, par_bit=0.
  - Shift register and counters clear.
  - Applies immediately, including mid-frame; no partial frame resumes after release.
- Handshake: a transfer happens on a rising clk edge with in_valid & in_ready.
  - At that edge the block latches in_data into the shift register.
  - It registers parity: even parity = XOR of all DATA_W bits.
  - State moves to START.
- in_valid and in_data are ignored while busy. The producer must hold in_valid until in_ready.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. Go to START on handshake.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out = shift register bit 0. Shift right every CLKS_PER_BIT cycles. Bit counter runs 0..DATA_W-1, then go to PARITY.
  - PARITY: tx_out=par_bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- done=1 for exactly the first IDLE cycle after STOP.
- Latency and timing:
  - tx_out falls in the first cycle after the handshake edge.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles.
  - done is asserted in the cycle after the last STOP cycle.
- Back-to-back frames: in_ready returns high together with done. A word can be accepted on that same edge, giving at most one idle-high cycle between frames.
- Counters:
  - Clock-divider counter width = clog2(CLKS_PER_BIT), minimum 1. It wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width = clog2(DATA_W). It is never compared beyond DATA_W-1.
- All outputs are registered. No combinational path from in_valid to tx_out.

Optional Feature:
- Macro PARITY_ODD_EN.
- Defined: par_bit = ~(XOR of data), i.e. odd parity, and the transmitted parity bit uses that value.
- Undefined: even parity as above.
- Nothing else changes, including reset value par_bit=0.

Decomposition:
- Shared package parity_pkg holds:
  - state encoding constants ST_IDLE=0, ST_START=1, ST_DATA=2, ST_PARITY=3, ST_STOP=4 (3-bit);
  - the line idle level constant LINE_IDLE=1.
- One sub-module: parity_tree.
  - Combinational XOR reduction of a DATA_W-bit vector with odd/even select input.
  - Built from 4-input parity cells so it reuses the existing generator structure.
  - Instantiated once on the input-latch path.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
1. Send 0xA5 (four ones): tx_out sequence is 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit for 4 cycles. par_bit=0, done pulses 44 cycles after the handshake edge. With PARITY_ODD_EN, the parity slot is 1.
2. Send 0x07: data bits 1,1,1,0,0,0,0,0, parity=1. Send 0x00: parity=0. Send 0xFF: parity=0.
3. Hold in_valid=1 with in_data changing during a frame: no second acceptance until done. The next frame carries the in_data value present on the done cycle. Exactly one idle cycle appears between the stop bit and the next start bit.
4. Assert rst_n=0 at cycle 20 of a frame (mid-DATA): the same cycle, tx_out=1, busy=0, in_ready=1, done=0. After release, no residual bits are sent; a new word transmits cleanly.
5. Reset values check: apply rst_n=0 with no clock running. All outputs take their reset values with no clk edge.
6. CLKS_PER_BIT=1 build: send 0x3C. Frame is 11 cycles, parity=0, done in cycle 12.
